// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding and the default burst limit.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter-FIFO bundle for uart_tx_arb.
// The slave side is the arbiter; the master side drives requests.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_data;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 frame_done;
  logic [IDW-1:0]       frame_done_id;

  modport slave (
    input  req_en, req_valid, req_data,
    input  req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_data,
    output busy, grant_id,
    output frame_done, frame_done_id
  );

  modport master (
    output req_en, req_valid, req_data,
    output req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data,
    input  busy, grant_id,
    input  frame_done, frame_done_id
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin pick: first set request above i_last, wrapping.
// Each index gets its rotated distance; smallest distance wins.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  int w_best;
  int w_dist;

  always_comb begin
    o_idx  = i_last;
    o_any  = |i_req;
    w_best = N;
    w_dist = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + 2 * N - int'(i_last) - 1) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter FIFO.
// Grants are held per frame, released on last or burst limit.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arb_if.slave bus
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_grant;
  logic [7:0]     r_cnt;
  logic           r_done;
  logic [IDW-1:0] r_done_id;

  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_acc_ok;
  logic           w_valid_g;
  logic           w_last_g;
  logic [7:0]     w_data_g;
  logic           w_wr;
  logic [7:0]     w_cnt_inc;
  logic           w_release;
  logic [NUM_REQ-1:0] w_ready;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .i_req  (bus.req_valid & bus.req_en),
    .i_last (r_grant),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  always_comb begin
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_data_g  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_valid_g = bus.req_valid[i];
        w_last_g  = bus.req_last[i];
        w_data_g  = bus.req_data[8*i +: 8];
      end
    end
  end

  // rst_n gates the strobes so a mid-frame reset stops writes at once
  assign w_acc_ok  = rst_n && (r_state == ST_XFER)
                     && !bus.fifo_full;
  assign w_wr      = w_acc_ok && w_valid_g;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_release = w_wr && (w_last_g
                     || (w_cnt_inc == 8'(MAX_BURST)));

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_acc_ok && (r_grant == IDW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_XFER;
      ST_XFER: if (w_release) w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant   <= IDW'(NUM_REQ - 1);
      r_cnt     <= 8'd0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_done <= w_release;
      if ((r_state == ST_IDLE) && w_any) begin
        r_grant <= w_win;
        r_cnt   <= 8'd0;
      end else if (w_wr) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_release) r_done_id <= r_grant;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.fifo_wr_en    = w_wr;
  assign bus.fifo_data     = w_wr ? w_data_g : 8'h00;
  assign bus.busy          = (r_state == ST_XFER);
  assign bus.grant_id      = r_grant;
  assign bus.frame_done    = r_done;
  assign bus.frame_done_id = r_done_id;

endmodule
